// File: rtl/fifo_flush_pkg.sv
// Shared types and defaults for the FIFO pointer flush controller.
// Optional DRAIN timeout is enabled by defining FLUSH_TIMEOUT_EN.
package fifo_flush_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      RESET = 2'd2,
      DONE  = 2'd3
   } flush_state_t;

   localparam int DEF_SETTLE_CYC  = 4;
   localparam int DEF_TIMEOUT_CYC = 1024;

   // One counter covers both windows, so size it for the longer one plus a spare bit.
   function automatic int cnt_width(input int settle, input int tmo);
      return $clog2((settle > tmo) ? settle : tmo) + 1;
   endfunction

endpackage

// File: rtl/flush_cycle_counter.sv
// Saturating cycle counter shared by the settle window and the DRAIN timeout.
// Synchronous clear has priority over enable.
module flush_cycle_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Saturates at all-ones so a long dwell never wraps back to a matching value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != '1))
         count <= count + ONE;
   end

endmodule

// File: rtl/fifo_flush_ctrl.sv
// Flush sequencer for a Gray-coded FIFO pointer pair: block writes, drain, reset pointers, handshake.
// Define FLUSH_TIMEOUT_EN to bound the DRAIN phase to TIMEOUT_CYC cycles.
module fifo_flush_ctrl
   import fifo_flush_pkg::*;
#(
   parameter int PTR_W       = 32,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_req,
   output logic             flush_ack,
   output logic             busy,
   input  logic             wr_req,
   output logic             wr_en,
   input  logic [PTR_W-1:0] wr_ptr_gray,
   input  logic [PTR_W-1:0] rd_ptr_gray_sync,
   output logic             ptr_rst_n,
   output logic             timeout
);

   localparam int CNT_W = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
`ifdef FLUSH_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic set_timeout;
`endif

   flush_state_t state;
   flush_state_t next_state;
   logic [CNT_W-1:0] cnt;
   logic ptr_match;

   assign ptr_match = (wr_ptr_gray == rd_ptr_gray_sync);
   assign wr_en     = wr_req & (state == IDLE);

   flush_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (next_state != state),
      .enable ((state == DRAIN) || (state == RESET)),
      .count  (cnt)
   );

   // A pointer match wins over a timeout landing on the same cycle.
   always_comb begin
      next_state = state;
`ifdef FLUSH_TIMEOUT_EN
      set_timeout = 1'b0;
`endif
      case (state)
         IDLE:  if (flush_req) next_state = DRAIN;
         DRAIN: begin
            if (ptr_match)
               next_state = RESET;
`ifdef FLUSH_TIMEOUT_EN
            else if (cnt == TIMEOUT_LAST) begin
               next_state  = RESET;
               set_timeout = 1'b1;
            end
`endif
         end
         RESET: if (cnt == SETTLE_LAST) next_state = DONE;
         DONE:  if (!flush_req) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         flush_ack <= 1'b0;
         busy      <= 1'b0;
         ptr_rst_n <= 1'b1;
      end else begin
         state     <= next_state;
         flush_ack <= (next_state == DONE);
         busy      <= (next_state != IDLE);
         ptr_rst_n <= (next_state != RESET);
      end
   end

`ifdef FLUSH_TIMEOUT_EN
   // Sticky until the next flush starts, so software can inspect why the last one ended.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         timeout <= 1'b0;
      else if ((state == IDLE) && (next_state == DRAIN))
         timeout <= 1'b0;
      else if (set_timeout)
         timeout <= 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flush_ctrl.sv
// Directed self-checking bench for fifo_flush_ctrl; covers the timeout path when FLUSH_TIMEOUT_EN is defined.
module tb_fifo_flush_ctrl;

   logic        clk;
   logic        rst;
   logic        flush_req;
   logic        flush_ack;
   logic        busy;
   logic        wr_req;
   logic        wr_en;
   logic [31:0] wr_ptr_gray;
   logic [31:0] rd_ptr_gray_sync;
   logic        ptr_rst_n;
   logic        timeout;

   int checks;
   int fails;

   fifo_flush_ctrl #(
      .PTR_W       (32),
      .SETTLE_CYC  (4),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .flush_req        (flush_req),
      .flush_ack        (flush_ack),
      .busy             (busy),
      .wr_req           (wr_req),
      .wr_en            (wr_en),
      .wr_ptr_gray      (wr_ptr_gray),
      .rd_ptr_gray_sync (rd_ptr_gray_sync),
      .ptr_rst_n        (ptr_rst_n),
      .timeout          (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic wreq, input logic [31:0] wp, input logic [31:0] rp);
      flush_req        = req;
      wr_req           = wreq;
      wr_ptr_gray      = wp;
      rd_ptr_gray_sync = rp;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   initial begin
      checks = 0;
      fails  = 0;
      rst    = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_ptr_rst_n", ptr_rst_n, 1);
      checkOutput("rst_flush_ack", flush_ack, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_timeout", timeout, 0);
      checkOutput("rst_wr_en", wr_en, 1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("idle_wr_en", wr_en, 1);
      checkOutput("idle_busy", busy, 0);

      // Equal pointers: minimum latency flush
      $display("[TB] equal-pointer flush");
      applyStimulus(1'b1, 1'b1, 32'h5, 32'h5);
      #1 checkOutput("eq_same_cycle_wr_en", wr_en, 1);
      for (int i = 0; i <= 7; i++) begin
         @(negedge clk);
         checkOutput($sformatf("eq_wr_en_e%0d", i), wr_en, 0);
         checkOutput($sformatf("eq_busy_e%0d", i), busy, 1);
         checkOutput($sformatf("eq_ptr_rst_n_e%0d", i), ptr_rst_n, (i >= 1 && i <= 4) ? 0 : 1);
         checkOutput($sformatf("eq_ack_e%0d", i), flush_ack, (i >= 5) ? 1 : 0);
      end
      applyStimulus(1'b0, 1'b1, 32'h5, 32'h5);
      @(negedge clk);
      checkOutput("eq_release_ack", flush_ack, 0);
      checkOutput("eq_release_busy", busy, 0);
      checkOutput("eq_release_wr_en", wr_en, 1);

      // Read pointer catches up after 10 DRAIN cycles
      $display("[TB] delayed-match flush");
      applyStimulus(1'b1, 1'b1, 32'h3, 32'h0);
      for (int i = 0; i <= 14; i++) begin
         @(negedge clk);
         checkOutput($sformatf("dm_wr_en_e%0d", i), wr_en, 0);
         checkOutput($sformatf("dm_busy_e%0d", i), busy, 1);
         checkOutput($sformatf("dm_ptr_rst_n_e%0d", i), ptr_rst_n, (i >= 10 && i <= 13) ? 0 : 1);
         checkOutput($sformatf("dm_ack_e%0d", i), flush_ack, (i >= 14) ? 1 : 0);
         if (i == 9) applyStimulus(1'b1, 1'b1, 32'h3, 32'h3);
      end
      applyStimulus(1'b0, 1'b1, 32'h3, 32'h3);
      @(negedge clk);
      checkOutput("dm_release_ack", flush_ack, 0);
      checkOutput("dm_release_busy", busy, 0);

`ifdef FLUSH_TIMEOUT_EN
      // Pointers never match: timeout forces RESET on the 16th DRAIN edge
      $display("[TB] timeout flush");
      applyStimulus(1'b1, 1'b1, 32'h3, 32'h0);
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk);
         checkOutput($sformatf("to_ptr_rst_n_e%0d", i), ptr_rst_n, (i >= 16 && i <= 19) ? 0 : 1);
         checkOutput($sformatf("to_timeout_e%0d", i), timeout, (i >= 16) ? 1 : 0);
         checkOutput($sformatf("to_ack_e%0d", i), flush_ack, (i >= 20) ? 1 : 0);
      end
      applyStimulus(1'b0, 1'b1, 32'h3, 32'h0);
      @(negedge clk);
      checkOutput("to_release_busy", busy, 0);
      checkOutput("to_sticky_timeout", timeout, 1);
      applyStimulus(1'b1, 1'b1, 32'h5, 32'h5);
      @(negedge clk);
      checkOutput("to_new_flush_timeout", timeout, 0);
      checkOutput("to_new_flush_busy", busy, 1);
      repeat (5) @(negedge clk);
      checkOutput("to_new_flush_ack", flush_ack, 1);
      applyStimulus(1'b0, 1'b1, 32'h5, 32'h5);
      @(negedge clk);
      checkOutput("to_new_flush_idle", busy, 0);
`else
      // Without the timeout feature DRAIN waits for a match indefinitely
      $display("[TB] unbounded drain");
      applyStimulus(1'b1, 1'b1, 32'h3, 32'h0);
      for (int i = 0; i <= 19; i++) begin
         @(negedge clk);
         checkOutput($sformatf("nt_ptr_rst_n_e%0d", i), ptr_rst_n, 1);
         checkOutput($sformatf("nt_timeout_e%0d", i), timeout, 0);
         checkOutput($sformatf("nt_busy_e%0d", i), busy, 1);
         checkOutput($sformatf("nt_ack_e%0d", i), flush_ack, 0);
      end
      applyStimulus(1'b1, 1'b1, 32'h3, 32'h3);
      repeat (5) @(negedge clk);
      checkOutput("nt_ack", flush_ack, 1);
      checkOutput("nt_timeout_final", timeout, 0);
      applyStimulus(1'b0, 1'b1, 32'h3, 32'h3);
      @(negedge clk);
      checkOutput("nt_release_busy", busy, 0);
`endif

      // Asynchronous reset during the settle window
      $display("[TB] reset mid-flush");
      applyStimulus(1'b1, 1'b1, 32'h5, 32'h5);
      repeat (3) @(negedge clk);
      checkOutput("mr_ptr_rst_n_before", ptr_rst_n, 0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'h5, 32'h5);
      #1;
      checkOutput("mr_ptr_rst_n", ptr_rst_n, 1);
      checkOutput("mr_ack", flush_ack, 0);
      checkOutput("mr_busy", busy, 0);
      checkOutput("mr_timeout", timeout, 0);
      checkOutput("mr_wr_en", wr_en, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mr_after_busy", busy, 0);
      checkOutput("mr_after_ptr_rst_n", ptr_rst_n, 1);

      // Request released during DRAIN: flush still completes with a one-cycle ack
      $display("[TB] early release");
      applyStimulus(1'b1, 1'b1, 32'h3, 32'h0);
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         checkOutput($sformatf("er_ptr_rst_n_e%0d", i), ptr_rst_n, (i >= 5 && i <= 8) ? 0 : 1);
         checkOutput($sformatf("er_ack_e%0d", i), flush_ack, (i == 9) ? 1 : 0);
         checkOutput($sformatf("er_busy_e%0d", i), busy, (i <= 9) ? 1 : 0);
         checkOutput($sformatf("er_wr_en_e%0d", i), wr_en, (i >= 10) ? 1 : 0);
         if (i == 2) applyStimulus(1'b0, 1'b1, 32'h3, 32'h0);
         if (i == 4) applyStimulus(1'b0, 1'b1, 32'h3, 32'h3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
